// File: rtl/pong_game_sequencer_pkg.sv
// Shared definitions for the Pong game-flow sequencer.
// Contents:
//   state_t      - 2-bit game state encoding
//   ctl_t        - bundle of the control nets driven to the playfield
//   DEF_*        - default timing and score constants
//   decode_ctl() - control-net values that belong to each state
package pong_game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ATTRACT    = 2'd0,
        ST_RESET      = 2'd1,
        ST_SERVE_WAIT = 2'd2,
        ST_PLAY       = 2'd3
    } state_t;

    typedef struct packed {
        logic attract;
        logic stop_g;
        logic srst;
        logic rst_speed;
        logic serve;
    } ctl_t;

    localparam int DEF_CLK_HZ       = 7_159_000;
    localparam int DEF_SERVE_DLY_MS = 1700;
    localparam int DEF_WIN_SCORE    = 11;
    localparam int DEF_MAX_CREDITS  = 9;
    localparam int DEF_SRST_CYCLES  = 16;

    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            ST_ATTRACT: begin
                c.attract = 1'b1;
                c.stop_g  = 1'b1;
            end
            ST_RESET:      c.srst      = 1'b1;
            ST_SERVE_WAIT: c.rst_speed = 1'b1;
            ST_PLAY:       c.serve     = 1'b1;
            default:       c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pong_game_sequencer_rise_det.sv
// rise_det: registered rising-edge detector.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   d     - synchronous input level
//   pulse - one-cycle pulse, registered on the edge after d was seen
//           high with the history register low
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic hist;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            hist  <= d;
            pulse <= d & ~hist;
        end
    end

endmodule

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer: game-flow controller for the Pong core.
// Takes coins into a saturating credit count, starts a game by spending a
// credit, pulses the score reset, times the serve delay, scores misses and
// returns to attract mode at the winning score.
// Ports:
//   clk7_159            - system clock, rising edge
//   rst                 - asynchronous active-high reset
//   coin_sw             - coin switch level (rising edge adds a credit)
//   miss_l / miss_r     - ball passed left / right paddle (rising edge)
//   srst / _srst        - score/game reset and complement
//   rst_speed           - hold ball speed at minimum
//   attract / _attract  - attract mode and complement
//   serve / _serve      - ball in play and complement
//   stop_g              - game stopped
//   score_l / score_r   - player scores
//   credits             - credits available
module pong_game_sequencer
    import pong_game_sequencer_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int SERVE_DLY_MS = DEF_SERVE_DLY_MS,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int MAX_CREDITS  = DEF_MAX_CREDITS,
    parameter int SRST_CYCLES  = DEF_SRST_CYCLES
) (
    input  logic       clk7_159,
    input  logic       rst,
    input  logic       coin_sw,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       srst,
    output logic       _srst,
    output logic       rst_speed,
    output logic       attract,
    output logic       _attract,
    output logic       serve,
    output logic       _serve,
    output logic       stop_g,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [3:0] credits
);

    localparam int SERVE_CYCLES = CLK_HZ / 1000 * SERVE_DLY_MS;
    // The one counter serves both RESET and SERVE_WAIT, so it must hold
    // the larger of the two reload values.
    localparam int CNT_MAX = (SERVE_CYCLES > SRST_CYCLES) ? SERVE_CYCLES : SRST_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SRST_LOAD  = CNT_W'(SRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_CYCLES - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
    localparam logic [3:0]       CRED_MAX   = 4'(MAX_CREDITS);

    state_t           state;
    ctl_t             ctl;
    logic [CNT_W-1:0] cnt;
    logic             coin_ev, miss_l_ev, miss_r_ev;
    logic             start_game;
    logic [3:0]       score_l_inc, score_r_inc;

    rise_det u_coin   (.clk(clk7_159), .rst(rst), .d(coin_sw), .pulse(coin_ev));
    rise_det u_miss_l (.clk(clk7_159), .rst(rst), .d(miss_l),  .pulse(miss_l_ev));
    rise_det u_miss_r (.clk(clk7_159), .rst(rst), .d(miss_r),  .pulse(miss_r_ev));

    assign start_game  = (state == ST_ATTRACT) && (credits != 4'd0);
    assign score_l_inc = score_l + 4'd1;
    assign score_r_inc = score_r + 4'd1;

    always_ff @(posedge clk7_159 or posedge rst) begin
        if (rst) begin
            state   <= ST_ATTRACT;
            ctl     <= decode_ctl(ST_ATTRACT);
            cnt     <= '0;
            score_l <= 4'd0;
            score_r <= 4'd0;
            credits <= 4'd0;
        end else begin
            // A coin landing on the consuming edge cancels out.
            if (coin_ev && !start_game && credits != CRED_MAX)
                credits <= credits + 4'd1;
            else if (start_game && !coin_ev)
                credits <= credits - 4'd1;

            // Control nets are reloaded together with the state so they
            // leave the flops already matching the new state.
            case (state)
                ST_ATTRACT: begin
                    if (start_game) begin
                        score_l <= 4'd0;
                        score_r <= 4'd0;
                        cnt     <= SRST_LOAD;
                        state   <= ST_RESET;
                        ctl     <= decode_ctl(ST_RESET);
                    end
                end
                ST_RESET: begin
                    if (cnt == '0) begin
                        cnt   <= SERVE_LOAD;
                        state <= ST_SERVE_WAIT;
                        ctl   <= decode_ctl(ST_SERVE_WAIT);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SERVE_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_PLAY;
                        ctl   <= decode_ctl(ST_PLAY);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PLAY: begin
                    // miss_l wins a tie, so only score_r moves.
                    if (miss_l_ev) begin
                        score_r <= score_r_inc;
                        if (score_r_inc == WIN) begin
                            state <= ST_ATTRACT;
                            ctl   <= decode_ctl(ST_ATTRACT);
                        end else begin
                            cnt   <= SERVE_LOAD;
                            state <= ST_SERVE_WAIT;
                            ctl   <= decode_ctl(ST_SERVE_WAIT);
                        end
                    end else if (miss_r_ev) begin
                        score_l <= score_l_inc;
                        if (score_l_inc == WIN) begin
                            state <= ST_ATTRACT;
                            ctl   <= decode_ctl(ST_ATTRACT);
                        end else begin
                            cnt   <= SERVE_LOAD;
                            state <= ST_SERVE_WAIT;
                            ctl   <= decode_ctl(ST_SERVE_WAIT);
                        end
                    end
                end
                default: begin
                    state <= ST_ATTRACT;
                    ctl   <= decode_ctl(ST_ATTRACT);
                end
            endcase
        end
    end

    assign attract   = ctl.attract;
    assign stop_g    = ctl.stop_g;
    assign srst      = ctl.srst;
    assign rst_speed = ctl.rst_speed;
    assign serve     = ctl.serve;
    assign _attract  = ~ctl.attract;
    assign _srst     = ~ctl.srst;
    assign _serve    = ~ctl.serve;

endmodule

// File: tb/tb_pong_game_sequencer.sv
module tb_pong_game_sequencer;

    localparam int CLK_HZ       = 1000;
    localparam int SERVE_DLY_MS = 10;
    localparam int WIN_SCORE    = 3;
    localparam int MAX_CREDITS  = 2;
    localparam int SRST_CYCLES  = 16;
    localparam int SERVE_CYCLES = CLK_HZ / 1000 * SERVE_DLY_MS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coin_sw = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
    logic srst, n_srst, rst_speed, attract, n_attract, serve, n_serve, stop_g;
    logic [3:0] score_l, score_r, credits;

    pong_game_sequencer #(
        .CLK_HZ(CLK_HZ), .SERVE_DLY_MS(SERVE_DLY_MS), .WIN_SCORE(WIN_SCORE),
        .MAX_CREDITS(MAX_CREDITS), .SRST_CYCLES(SRST_CYCLES)
    ) dut (
        .clk7_159(clk), .rst(rst), .coin_sw(coin_sw), .miss_l(miss_l), .miss_r(miss_r),
        .srst(srst), ._srst(n_srst), .rst_speed(rst_speed),
        .attract(attract), ._attract(n_attract), .serve(serve), ._serve(n_serve),
        .stop_g(stop_g), .score_l(score_l), .score_r(score_r), .credits(credits)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game phase plus cycles spent in it.
    // Phases: 0 attract, 1 score reset, 2 serve wait, 3 play.
    int m_phase, m_elapsed, m_credits, m_sl, m_sr, m_next;
    bit m_start;
    bit h_coin, h_ml, h_mr;   // input level seen on the previous edge
    bit p_coin, p_ml, p_mr;   // edges seen last cycle, acted on this edge

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_credits = 0; m_sl = 0; m_sr = 0;
            h_coin = 0; h_ml = 0; h_mr = 0; p_coin = 0; p_ml = 0; p_mr = 0;
        end else begin
            m_start = (m_phase == 0) && (m_credits > 0);
            m_next  = m_credits + (p_coin ? 1 : 0) - (m_start ? 1 : 0);
            m_credits = (m_next > MAX_CREDITS) ? MAX_CREDITS : m_next;
            case (m_phase)
                0: if (m_start) begin m_phase = 1; m_elapsed = 0; m_sl = 0; m_sr = 0; end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == SRST_CYCLES) begin m_phase = 2; m_elapsed = 0; end
                end
                2: begin
                    m_elapsed++;
                    if (m_elapsed == SERVE_CYCLES) m_phase = 3;
                end
                default: if (p_ml || p_mr) begin
                    if (p_ml) m_sr++; else m_sl++;
                    if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) m_phase = 0;
                    else begin m_phase = 2; m_elapsed = 0; end
                end
            endcase
            p_coin = coin_sw && !h_coin; h_coin = coin_sw;
            p_ml   = miss_l  && !h_ml;   h_ml   = miss_l;
            p_mr   = miss_r  && !h_mr;   h_mr   = miss_r;
        end
    end

    // Compare every cycle once the bench has started.
    always @(negedge clk) begin
        if (check_en) begin
            check("attract",   attract,   m_phase == 0);
            check("_attract",  n_attract, m_phase != 0);
            check("stop_g",    stop_g,    m_phase == 0);
            check("srst",      srst,      m_phase == 1);
            check("_srst",     n_srst,    m_phase != 1);
            check("rst_speed", rst_speed, m_phase == 2);
            check("serve",     serve,     m_phase == 3);
            check("_serve",    n_serve,   m_phase != 3);
            check("score_l",   score_l,   m_sl);
            check("score_r",   score_r,   m_sr);
            check("credits",   credits,   m_credits);
        end
    end

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return srst;
            1:       return rst_speed;
            default: return serve;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input string name);
        int n;
        n = 0;
        while (get_sig(sel) !== val && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({"wait_", name}, get_sig(sel), val);
    endtask

    task automatic count_high(input int sel, output int n);
        n = 0;
        while (get_sig(sel) === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic coin_pulse();
        @(negedge clk); #1 coin_sw = 1'b1;
        @(negedge clk); #1 coin_sw = 1'b0;
    endtask

    task automatic miss_pulse(input bit l, input bit r);
        @(negedge clk); #1 miss_l = l; miss_r = r;
        @(negedge clk); #1 miss_l = 1'b0; miss_r = 1'b0;
    endtask

    int n_cyc, n_seen;

    initial begin
        // 1: reset and idle
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        check_en = 1'b1;
        n_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (srst) n_seen++;
        end
        check("idle_srst_cycles", n_seen, 0);
        check("idle_attract", attract, 1);
        check("idle_stop_g", stop_g, 1);
        check("idle_serve", serve, 0);
        check("idle_credits", credits, 0);

        // 2: one coin starts a game
        coin_pulse();
        @(negedge clk);
        check("coin_credit_one", credits, 1);
        wait_for(0, 1'b1, "srst_rise");
        check("start_credit_zero", credits, 0);
        count_high(0, n_cyc);
        check("srst_len", n_cyc, 16);
        count_high(1, n_cyc);
        check("rst_speed_len", n_cyc, 10);
        check("serve_after_wait", serve, 1);

        // 3: miss_l scores for the right; miss during wait ignored
        miss_pulse(1'b1, 1'b0);
        wait_for(2, 1'b0, "serve_fall");
        check("miss_l_score_r", score_r, 1);
        check("miss_l_score_l", score_l, 0);
        miss_pulse(1'b0, 1'b1);
        wait_for(2, 1'b1, "serve_again");
        check("wait_miss_score_l", score_l, 0);
        check("wait_miss_score_r", score_r, 1);

        // 4: three miss_r end the game
        for (int i = 0; i < 3; i++) begin
            miss_pulse(1'b0, 1'b1);
            wait_for(2, 1'b0, "serve_fall_r");
            if (i < 2) wait_for(2, 1'b1, "serve_rise_r");
        end
        @(negedge clk);
        check("end_score_l", score_l, 3);
        check("end_attract", attract, 1);
        check("end_stop_g", stop_g, 1);
        check("model_score_l", m_sl, 3);
        repeat (20) @(negedge clk);
        check("held_score_l", score_l, 3);
        check("held_score_r", score_r, 1);

        // 5: coin under reset ignored, then credits saturate
        @(negedge clk); #1 rst = 1'b1;
        coin_pulse();
        @(negedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_coin_credits", credits, 0);
        for (int i = 0; i < 4; i++) coin_pulse();
        repeat (4) @(negedge clk);
        check("sat_credits", credits, 2);
        check("model_sat_credits", m_credits, 2);
        wait_for(2, 1'b1, "serve_g2");
        for (int i = 0; i < 2; i++) begin
            miss_pulse(1'b1, 1'b0);
            wait_for(2, 1'b0, "serve_fall_g2");
            wait_for(2, 1'b1, "serve_rise_g2");
        end
        // Final miss, then a coin timed to land on the credit-consuming edge.
        @(negedge clk); #1 miss_l = 1'b1;
        @(negedge clk); #1 miss_l = 1'b0; coin_sw = 1'b1;
        @(negedge clk); #1 coin_sw = 1'b0;
        repeat (4) @(negedge clk);
        check("coincident_credits", credits, 2);
        check("restart_srst", srst, 1);

        // 6: simultaneous misses, then async reset in play
        wait_for(2, 1'b1, "serve_g3");
        miss_pulse(1'b1, 1'b1);
        wait_for(2, 1'b0, "serve_fall_both");
        check("both_score_r", score_r, 1);
        check("both_score_l", score_l, 0);
        wait_for(2, 1'b1, "serve_rise_both");
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("arst_attract", attract, 1);
        check("arst_n_attract", n_attract, 0);
        check("arst_stop_g", stop_g, 1);
        check("arst_serve", serve, 0);
        check("arst_n_serve", n_serve, 1);
        check("arst_srst", srst, 0);
        check("arst_n_srst", n_srst, 1);
        check("arst_rst_speed", rst_speed, 0);
        check("arst_scores", {score_l, score_r}, 0);
        check("arst_credits", credits, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Random phase against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            rst     = ($urandom_range(0, 599) == 0);
            coin_sw = ($urandom_range(0, 5) == 0);
            miss_l  = ($urandom_range(0, 3) == 0);
            miss_r  = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); #1 rst = 1'b0; coin_sw = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
